mm_seq_ctrl: RTL and testbench
==============================

// Module: mm_seq_ctrl
// PURPOSE
//  Sequencer for one systolic matrix-multiply pass. Accepts 2*DIM host rows (DIM A rows, then DIM B rows),
//  writes them into the skewing A/B operand memories, then clears the array. It then enables the operand
//  memories and the array for the full skewed compute window. Finally it streams the DIM result rows out.
//  Sits between the host MMIO/row interface and memA/memB/systolic array.
// PARAMETERS
//  DIM      8   matrix dimension (rows/cols of A, B, C)
//  BITS_AB  8   operand element width
// PORTS
//  clk        in   1               clock
//  rst_n      in   1               reset, asynchronous, active-low
//  start      in   1               begin a pass; honoured only in IDLE
//  abort      in   1               synchronous abort; any state -> IDLE
//  row_valid  in   1               host row valid
//  row_ready  out  1               host row ready (=1 only in LOAD)
//  row_data   in   DIM*BITS_AB     host row, element j at [j*BITS_AB +: BITS_AB]
//  mem_row    out  DIM*BITS_AB     registered copy of accepted row_data -> memA/memB Ain/Bin
//  memA_wr    out  1               memA WrEn
//  memB_wr    out  1               memB WrEn
//  mem_sel    out  $clog2(DIM)     row index for memA Arow / memB Brow
//  mem_en     out  1               memA/memB en (shift/skew advance)
//  sa_en      out  1               systolic array MAC enable (== mem_en)
//  sa_clr     out  1               systolic array accumulator clear
//  c_sel      out  $clog2(DIM)     result row select into array
//  res_valid  out  1               result row c_sel is valid
//  res_ready  in   1               consumer accepts result row
//  busy       out  1               state != IDLE
//  done       out  1               1-cycle pulse after last result handshake
// BEHAVIOUR
//  - Reset: state IDLE, all counters 0. All outputs 0, including mem_row, row_ready and done.
//  - All outputs registered except row_ready/res_valid/busy (decoded from state reg) and c_sel (counter reg).
//  - FSM states: IDLE, LOAD, SETTLE, RUN, READ.
//  - IDLE: start & !abort -> LOAD; ld_cnt=0.
//  - LOAD: row_ready=1. On handshake at cycle t: mem_row<=row_data, mem_sel<=ld_cnt%DIM.
//    memA_wr (ld_cnt<DIM) or memB_wr (ld_cnt>=DIM) is 1 in cycle t+1 only; ld_cnt++.
//    Idle row_valid cycles produce no write. Handshake with ld_cnt==2*DIM-1 -> SETTLE.
//  - SETTLE: exactly 1 cycle; final B write visible this cycle; sa_clr=1. -> RUN, run_cnt=0.
//  - RUN: mem_en=sa_en=1 for exactly RUN_CYCLES=3*DIM-2 consecutive cycles, then 0. -> READ, rd_cnt=0.
//  - READ: res_valid=1, c_sel=rd_cnt, held stable until res_ready. Handshake: rd_cnt++.
//    Handshake at rd_cnt==DIM-1 -> IDLE, done=1 next cycle for 1 cycle.
//  - Write and enable exclusion: memA_wr/memB_wr never assert together or with mem_en. sa_clr never
//    asserts with sa_en.
//  - start outside IDLE ignored. row_valid outside LOAD ignored (row_ready=0, no write).
//  - abort has priority over start and all handshakes. Next cycle: IDLE, all strobes 0, counters 0, no done.
//    A row handshake coincident with abort is dropped.
//  - rst_n low mid-pass: immediate IDLE and zero outputs; next pass restarts at A row 0.
//  - Counter widths: ld_cnt $clog2(2*DIM), run_cnt $clog2(3*DIM), rd_cnt $clog2(DIM)+1.
//    mem_sel=ld_cnt[$clog2(DIM)-1:0]. No counter wraps within a pass.
// STRUCTURE
//  - mm_pkg: typedef enum logic[2:0] mm_state_t {IDLE,LOAD,SETTLE,RUN,READ}, function run_cycles(dim)=3*dim-2.
//    mm_pkg is shared with memA/memB/array benches.
//  - Single flat module: FSM plus three counters. No sub-module is natural; none is instantiated.
// TESTING (DIM=8)
//  1. Reset: rst_n=0 -> every output 0, busy=0. Release, 5 idle cycles -> outputs still 0.
//  2. Full pass, row_valid held 1, res_ready held 1:
//     - memA_wr rows 0..7 on 8 consecutive cycles, then memB_wr rows 0..7; mem_row matches row_data.
//     - sa_clr 1 cycle, then mem_en=sa_en=1 for exactly 22 cycles.
//     - res_valid with c_sel 0..7 over 8 cycles; done pulse 1 cycle; busy low after.
//  3. Backpressure: row_valid 1-of-3 cycles, res_ready toggling:
//     - exactly 16 writes, 8 result handshakes.
//     - c_sel/res_valid stable while res_ready=0. mem_en count still 22.
//  4. start pulsed during LOAD, RUN and READ -> ignored, pass completes unchanged.
//     start & abort together in IDLE -> stays IDLE.
//  5. abort at RUN cycle 10 -> next cycle IDLE, mem_en 0, done never pulses.
//     New start -> first write memA_wr, mem_sel=0.
//  6. rst_n asserted after 5 rows loaded -> outputs 0 asynchronously.
//     After release + start -> writes restart at memA row 0; 16 writes total.

Source files
------------

// File: rtl/mm_pkg.sv
// mm_pkg: state encoding, default geometry and timing helper shared by the matmul sequencer and its neighbours
package mm_pkg;
  localparam int DIM_DEF = 8;
  localparam int BITS_AB_DEF = 8;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, READ} mm_state_t;
  // A skewed DIM x DIM systolic pass needs 3*DIM-2 advance cycles to drain the last partial product
  function automatic int run_cycles(input int dim);
    return 3 * dim - 2;
  endfunction
endpackage

// File: rtl/mm_seq_ctrl.sv
// mm_seq_ctrl: sequences operand load, array clear, skewed compute window and result readout for one matmul pass
module mm_seq_ctrl
  import mm_pkg::*;
#(
  parameter int DIM     = DIM_DEF,
  parameter int BITS_AB = BITS_AB_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     row_valid,
  output logic                     row_ready,
  input  logic [DIM*BITS_AB-1:0]   row_data,
  output logic [DIM*BITS_AB-1:0]   mem_row,
  output logic                     memA_wr,
  output logic                     memB_wr,
  output logic [$clog2(DIM)-1:0]   mem_sel,
  output logic                     mem_en,
  output logic                     sa_en,
  output logic                     sa_clr,
  output logic [$clog2(DIM)-1:0]   c_sel,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     busy,
  output logic                     done
);
  localparam int SW  = $clog2(DIM);
  localparam int LW  = $clog2(2 * DIM);
  localparam int RCW = $clog2(3 * DIM);
  localparam int DW  = $clog2(DIM) + 1;
  localparam logic [LW-1:0]  LD_LAST  = LW'(2 * DIM - 1);
  localparam logic [LW-1:0]  B_BASE   = LW'(DIM);
  localparam logic [RCW-1:0] RUN_LAST = RCW'(run_cycles(DIM) - 1);
  localparam logic [DW-1:0]  RD_LAST  = DW'(DIM - 1);

  mm_state_t                state_q;
  logic [LW-1:0]            ld_cnt_q;
  logic [RCW-1:0]           run_cnt_q;
  logic [DW-1:0]            rd_cnt_q;
  logic [DIM*BITS_AB-1:0]   row_q;
  logic [SW-1:0]            sel_q;
  logic                     wr_a_q, wr_b_q, en_q, clr_q, done_q;

  assign row_ready = state_q == LOAD;
  assign res_valid = state_q == READ;
  assign busy      = state_q != IDLE;
  assign c_sel     = rd_cnt_q[SW-1:0];
  assign mem_row   = row_q;
  assign mem_sel   = sel_q;
  assign memA_wr   = wr_a_q;
  assign memB_wr   = wr_b_q;
  assign mem_en    = en_q;
  assign sa_en     = en_q;
  assign sa_clr    = clr_q;
  assign done      = done_q;

  // Pass FSM: write strobes, clear and done are single-cycle pulses; the compute enable spans all of RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ld_cnt_q  <= '0;
      run_cnt_q <= '0;
      rd_cnt_q  <= '0;
      row_q     <= '0;
      sel_q     <= '0;
      wr_a_q    <= 1'b0;
      wr_b_q    <= 1'b0;
      en_q      <= 1'b0;
      clr_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_a_q <= 1'b0;
      wr_b_q <= 1'b0;
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      if (abort) begin
        state_q   <= IDLE;
        ld_cnt_q  <= '0;
        run_cnt_q <= '0;
        rd_cnt_q  <= '0;
        en_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            state_q  <= LOAD;
            ld_cnt_q <= '0;
          end
          LOAD: if (row_valid) begin
            row_q    <= row_data;
            sel_q    <= ld_cnt_q[SW-1:0];
            wr_a_q   <= ld_cnt_q < B_BASE;
            wr_b_q   <= ld_cnt_q >= B_BASE;
            ld_cnt_q <= ld_cnt_q == LD_LAST ? '0 : ld_cnt_q + 1'b1;
            if (ld_cnt_q == LD_LAST) begin
              state_q <= SETTLE;
              clr_q   <= 1'b1;
            end
          end
          SETTLE: begin
            state_q   <= RUN;
            run_cnt_q <= '0;
            en_q      <= 1'b1;
          end
          RUN: if (run_cnt_q == RUN_LAST) begin
            state_q   <= READ;
            run_cnt_q <= '0;
            rd_cnt_q  <= '0;
            en_q      <= 1'b0;
          end else begin
            run_cnt_q <= run_cnt_q + 1'b1;
          end
          READ: if (res_ready) begin
            rd_cnt_q <= rd_cnt_q == RD_LAST ? '0 : rd_cnt_q + 1'b1;
            if (rd_cnt_q == RD_LAST) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mm_seq_ctrl.sv
// tb_mm_seq_ctrl: table-driven pass scenarios plus directed reset/abort sequences for the matmul sequencer
module tb_mm_seq_ctrl;
  localparam int DIM  = 8;
  localparam int BITS = 8;
  localparam int RW   = DIM * BITS;
  localparam int SW   = $clog2(DIM);

  logic          clk, rst_n, start, abort, row_valid, res_ready;
  logic [RW-1:0] row_data, mem_row;
  logic          row_ready, memA_wr, memB_wr, mem_en, sa_en, sa_clr, res_valid, busy, done;
  logic [SW-1:0] mem_sel, c_sel;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int rv_per;
    int rr_per;
    bit poke;
    int exp_wr;
    int exp_en;
    int exp_hs;
  } scen_t;

  scen_t tbl[4];

  mm_seq_ctrl #(.DIM(DIM), .BITS_AB(BITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .mem_row(mem_row), .memA_wr(memA_wr), .memB_wr(memB_wr), .mem_sel(mem_sel),
    .mem_en(mem_en), .sa_en(sa_en), .sa_clr(sa_clr), .c_sel(c_sel),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic logic [RW-1:0] row_pat(input int k);
    logic [RW-1:0] r;
    for (int j = 0; j < DIM; j++) r[j*BITS +: BITS] = BITS'(k * 17 + j * 3 + 1);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_row"}, mem_row, 0);
    chk({tag, "_strobes"}, {row_ready, memA_wr, memB_wr, mem_en, sa_en, sa_clr, res_valid, busy, done}, 0);
    chk({tag, "_sels"}, {mem_sel, c_sel}, 0);
  endtask

  // One full pass from IDLE; caller is at a falling edge. Every cycle is checked against a running model.
  task automatic run_pass(input scen_t s);
    int k, rd, n_wr, n_en, n_hs, n_clr, n_done, en_starts, pend_k;
    bit pend, prev_en, prev_clr, prev_hold, exp_done, fin;
    k = 0; rd = 0; n_wr = 0; n_en = 0; n_hs = 0; n_clr = 0; n_done = 0; en_starts = 0; pend_k = 0;
    pend = 0; prev_en = 0; prev_clr = 0; prev_hold = 0; exp_done = 0; fin = 0;
    start = 1'b1;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      @(negedge clk);
      if (pend || memA_wr || memB_wr) begin
        chk("wr_a", memA_wr, pend && pend_k < DIM);
        chk("wr_b", memB_wr, pend && pend_k >= DIM);
        chk("wr_excl_en", mem_en, 0);
        if (pend) begin
          chk("mem_sel", mem_sel, pend_k % DIM);
          chk("mem_row", mem_row, row_pat(pend_k));
        end
        if (memA_wr || memB_wr) n_wr++;
      end
      chk("row_ready", row_ready, k < 2 * DIM);
      if (sa_clr) begin
        n_clr++;
        chk("clr_with_last_b", pend && pend_k == 2 * DIM - 1, 1);
        chk("clr_excl_en", sa_en, 0);
      end
      if (mem_en && !prev_en) begin
        en_starts++;
        chk("en_after_clr", prev_clr, 1);
      end
      if (mem_en || sa_en) chk("sa_en_eq_mem_en", sa_en, mem_en);
      if (mem_en) n_en++;
      if (prev_hold) chk("rv_hold", res_valid, 1);
      if (res_valid) begin
        chk("c_sel", c_sel, rd);
        chk("rv_excl_en", mem_en, 0);
        if (rd == 0 && n_hs == 0 && prev_en) chk("read_after_run", n_en, s.exp_en);
      end
      if (exp_done || done) begin
        chk("done", done, exp_done);
        if (done) n_done++;
      end
      if (exp_done) begin
        chk("busy_after_done", busy, 0);
        fin = 1;
      end
      exp_done = 0;
      row_valid = (cyc % s.rv_per) == 0;
      row_data = row_valid ? row_pat(k) : {(RW/16){16'hA5C3}};
      res_ready = (cyc % s.rr_per) == 0;
      start = s.poke && rd < DIM - 1 && (cyc % 2 == 1);
      pend = row_ready && row_valid;
      pend_k = k;
      if (pend) k++;
      prev_hold = res_valid && !res_ready;
      if (res_valid && res_ready) begin
        n_hs++;
        if (rd == DIM - 1) exp_done = 1;
        rd++;
      end
      prev_en = mem_en;
      prev_clr = sa_clr;
    end
    if (!fin) chk("pass_timeout", 0, 1);
    chk("n_writes", n_wr, s.exp_wr);
    chk("n_en", n_en, s.exp_en);
    chk("n_res_hs", n_hs, s.exp_hs);
    chk("n_clr", n_clr, 1);
    chk("n_done", n_done, 1);
    chk("en_contiguous", en_starts, 1);
    start = 1'b0; row_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    chk("done_single_cycle", done, 0);
    chk("idle_after_pass", busy, 0);
  endtask

  initial begin
    int w;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; row_valid = 1'b0; res_ready = 1'b0;
    row_data = row_pat(99);
    tbl[0] = '{1, 1, 1'b0, 16, 22, 8};
    tbl[1] = '{3, 2, 1'b0, 16, 22, 8};
    tbl[2] = '{1, 1, 1'b1, 16, 22, 8};
    tbl[3] = '{2, 3, 1'b1, 16, 22, 8};

    #3;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1; row_valid = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_zero("idle");
    end
    row_valid = 1'b0; res_ready = 1'b0;

    for (int i = 0; i < 4; i++) run_pass(tbl[i]);

    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("start_abort_idle", {busy, row_ready}, 0);
    start = 1'b0; abort = 1'b0;

    start = 1'b1; row_valid = 1'b1; row_data = row_pat(5);
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!mem_en && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("abort_reach_run", mem_en, 1);
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("abort_run_cycle10", mem_en, 1);
    abort = 1'b1; row_valid = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", {busy, mem_en, sa_en, sa_clr, res_valid}, 0);
    row_valid = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("abort_no_activity", {done, busy, memA_wr, memB_wr}, 0);
    end
    row_data = row_pat(0); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_load", row_ready, 1);
    @(negedge clk);
    chk("restart_wr_a", {memA_wr, memB_wr}, 2'b10);
    chk("restart_sel", mem_sel, 0);
    chk("restart_row", mem_row, row_pat(0));
    row_data = row_pat(1); abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; row_valid = 1'b0; res_ready = 1'b0;
    chk("abort_drops_row", {memA_wr, memB_wr, busy}, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0; row_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      row_data = row_pat(40 + i);
      @(negedge clk);
    end
    row_valid = 1'b0;
    chk("pre_reset_wr", {memA_wr, mem_sel}, {1'b1, 3'd4});
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_pass(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
